pxs_vga_source: RTL and testbench
=================================

# pxs_vga_source

Head of the RGB pixel-stream pipeline: generates VGA raster timing and emits the 26-bit RGB stream that overlay stages (character, sprite, box drawers) consume and forward. Carries active flag, sync levels, X/Y coordinates and a base test-pattern colour per pixel clock. Every downstream `Pxs*` stage depends on this block's field layout and coordinate meaning.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal front porch, sync, back porch (pixels).
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical porch and sync (lines).
- `HS_POL`, 0 / `VS_POL`, 0: sync-asserted level carried in the stream.
- `color_bg`, 3'b000: background colour {B,G,R}.

Ports:
- `px_clk` in 1: pixel clock. The only clock.
- `reset` in 1: synchronous, active-high.
- `pattern` in 2: pattern select. 0 solid, 1 bars, 2 checker, 3 frame cycle.
- `RGBStr_o` out 26: stream. [0] Active, [1] VS, [2] HS, [12:3] YC, [22:13] XC, [23] R, [24] G, [25] B.
- `frame_o` out 1: one-cycle pulse on the beat carrying XC=0, YC=0.

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Both must be ≤ 1024.
- Horizontal counter `hc` runs 0..H_TOTAL-1 and wraps. The vertical counter `vc` increments on the `hc` wrap and wraps at V_TOTAL-1.
- Active = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- HS = HS_POL when H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise ~HS_POL.
- VS = VS_POL when V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise ~VS_POL. VS changes aligned to hc=0.
- XC = hc, YC = vc for every beat, including blanking.
- RGB is 3'b000 whenever Active=0. During active pixels:
  - mode 0: `color_bg`.
  - mode 1: 8 vertical bars of H_ACTIVE/8 pixels; RGB = bar index 0..7.
    - Bar index comes from a bar sub-counter. No divider.
  - mode 2: (hc[3]^vc[3]) ? 3'b111 : `color_bg`.
  - mode 3: RGB = frame_cnt[7:5], where 8-bit frame_cnt increments on each frame wrap.
- `pattern` is sampled into an internal register only at the frame wrap (hc=H_TOTAL-1, vc=V_TOTAL-1) and at reset. Mid-frame changes take effect on the next frame.

## Timing
- Output fully registered. The beat for counter state (hc,vc) appears on `RGBStr_o` one cycle after the counters hold it.
- Reset values:
  - counters 0, frame_cnt 0.
  - pattern register = `pattern` at reset.
  - RGBStr_o: Active=0, HS=~HS_POL, VS=~VS_POL, XC=0, YC=0, RGB=0.
  - `frame_o`=0.
- First edge with `reset` low: counters hold (0,0). The next edge outputs the XC=0, YC=0 beat with Active=1 and `frame_o`=1.
- Reset asserted mid-line or mid-frame: at the next edge, counters and outputs take their reset values. No partial-line completion.
- Bar sub-counter clears at hc=0. Checker and frame-cycle modes use only counter bits.
- Frame wrap and line wrap are simultaneous at the frame end. vc goes to 0, not V_TOTAL.

## Structure
- Shared package `pxs_pkg`:
  - stream field positions: ACTIVE, VS, HS, YC_LSB/MSB, XC_LSB/MSB, R, G, B, RGB range, VGA range.
  - `STREAM_W`=26.
  - 640x480@60 timing constants.
- All stream stages import `pxs_pkg`.
- One sub-module, `pxs_raster_counter`:
  - hc/vc counters and wrap flags (`line_end`, `frame_end`).
  - Pattern, sync decode and output register stay in the top.

## Test plan
- Reset held 5 cycles, then released. Outputs match reset values while held. First post-reset beat is XC=0, YC=0, Active=1, `frame_o`=1.
- Line 0: HS at the asserted level exactly for XC 656..751. Active=1 for XC 0..639 and 0 from 640. Next line starts with YC=1 after XC=799.
- Frame: VS asserted for YC 490..491 only. After YC=524/XC=799 the next beat is YC=0/XC=0 with `frame_o`=1. `frame_o` pulses exactly once per 420000 cycles.
- pattern=1: RGB 0 at XC 0..79, 1 at XC 80, 7 at XC 639, 0 at XC 640. Pattern switched to 2 mid-frame: bars persist until the frame wrap, then the checker appears (XC 8, YC 0 → 3'b111).
- pattern=3: RGB=0 for frames 0..31 and 1 from frame 32. frame_cnt wraps 255→0.
- Reset asserted at XC=300, YC=200 for one cycle: next beat carries reset values. Timing restarts from (0,0) with no stale coordinates.

Source files
------------

// File: rtl/pxs_pkg.sv
// Shared definitions for the RGB pixel-stream pipeline: stream field layout,
// beat payload struct, pattern encodings and 640x480@60 raster timing.
package pxs_pkg;

   localparam int unsigned STREAM_W = 26;
   localparam int unsigned CNT_W    = 10;

   localparam int unsigned ACTIVE   = 0;
   localparam int unsigned VS       = 1;
   localparam int unsigned HS       = 2;
   localparam int unsigned YC_LSB   = 3;
   localparam int unsigned YC_MSB   = 12;
   localparam int unsigned XC_LSB   = 13;
   localparam int unsigned XC_MSB   = 22;
   localparam int unsigned R        = 23;
   localparam int unsigned G        = 24;
   localparam int unsigned B        = 25;
   localparam int unsigned RGB_LSB  = 23;
   localparam int unsigned RGB_MSB  = 25;
   localparam int unsigned VGA_LSB  = 0;
   localparam int unsigned VGA_MSB  = 2;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;

   typedef enum logic [1:0] {
      PAT_SOLID   = 2'd0,
      PAT_BARS    = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_FRAME   = 2'd3
   } pxs_pattern_e;

   // Packs MSB-first so the struct bit positions equal the stream field positions.
   typedef struct packed {
      logic [2:0]       rgb;     // {B,G,R}
      logic [CNT_W-1:0] xc;
      logic [CNT_W-1:0] yc;
      logic             hs;
      logic             vs;
      logic             active;
   } pxs_beat_t;

   function automatic logic in_window(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/pxs_raster_counter.sv
// Horizontal/vertical raster counters with registered end-of-line and
// end-of-frame flags describing the current counter state.
module pxs_raster_counter
   import pxs_pkg::*;
#(
   parameter int unsigned H_TOTAL = 800,
   parameter int unsigned V_TOTAL = 525
) (
   input  logic             clk_i,
   input  logic             reset_i,
   output logic [CNT_W-1:0] hc_o,
   output logic [CNT_W-1:0] vc_o,
   output logic             line_end_o,
   output logic             frame_end_o
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   logic [CNT_W-1:0] hc_q, hc_d;
   logic [CNT_W-1:0] vc_q, vc_d;
   logic             line_end_q, line_end_d;
   logic             frame_end_q, frame_end_d;

   // Flags are precomputed from the next state so they align with hc_q/vc_q.
   always_comb begin
      hc_d = hc_q + 1'b1;
      vc_d = vc_q;
      if (line_end_q) begin
         hc_d = '0;
         vc_d = frame_end_q ? '0 : vc_q + 1'b1;
      end
      line_end_d  = (hc_d == H_LAST);
      frame_end_d = (hc_d == H_LAST) && (vc_d == V_LAST);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         hc_q        <= '0;
         vc_q        <= '0;
         line_end_q  <= 1'b0;
         frame_end_q <= 1'b0;
      end else begin
         hc_q        <= hc_d;
         vc_q        <= vc_d;
         line_end_q  <= line_end_d;
         frame_end_q <= frame_end_d;
      end
   end

   assign hc_o        = hc_q;
   assign vc_o        = vc_q;
   assign line_end_o  = line_end_q;
   assign frame_end_o = frame_end_q;

endmodule

// File: rtl/pxs_vga_source.sv
// Head of the pixel-stream pipeline: VGA raster timing plus a selectable
// test-pattern colour, emitted as one registered stream beat per pixel clock.
module pxs_vga_source
   import pxs_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter logic        HS_POL   = 1'b0,
   parameter logic        VS_POL   = 1'b0,
   parameter logic [2:0]  color_bg = 3'b000
) (
   input  logic                px_clk,
   input  logic                reset,
   input  logic [1:0]          pattern,
   output logic [STREAM_W-1:0] RGBStr_o,
   output logic                frame_o
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned BAR_W   = H_ACTIVE / 8;

   localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

   logic [CNT_W-1:0] hc;
   logic [CNT_W-1:0] vc;
   logic             line_end;
   logic             frame_end;

   logic [CNT_W-1:0] bar_px_q, bar_px_d;
   logic [2:0]       bar_idx_q, bar_idx_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;
   pxs_pattern_e     pat_q, pat_d;
   pxs_beat_t        beat_q, beat_d;
   logic             frame_q, frame_d;
   logic             active_c;
   logic [2:0]       pat_rgb_c;

   pxs_raster_counter #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_raster (
      .clk_i       (px_clk),
      .reset_i     (reset),
      .hc_o        (hc),
      .vc_o        (vc),
      .line_end_o  (line_end),
      .frame_end_o (frame_end)
   );

   // Bar sub-counter shadows hc: position within the bar and the bar index.
   always_comb begin
      bar_px_d  = bar_px_q + 1'b1;
      bar_idx_d = bar_idx_q;
      if (line_end) begin
         bar_px_d  = '0;
         bar_idx_d = '0;
      end else if (bar_px_q == BAR_LAST) begin
         bar_px_d  = '0;
         bar_idx_d = bar_idx_q + 3'd1;
      end
   end

   // Pattern select and frame counter only move at the frame wrap.
   always_comb begin
      pat_d       = pat_q;
      frame_cnt_d = frame_cnt_q;
      if (frame_end) begin
         pat_d       = pxs_pattern_e'(pattern);
         frame_cnt_d = frame_cnt_q + 8'd1;
      end
   end

   always_comb begin
      active_c  = (hc < H_ACT_C) && (vc < V_ACT_C);
      pat_rgb_c = color_bg;
      case (pat_q)
         PAT_SOLID:   pat_rgb_c = color_bg;
         PAT_BARS:    pat_rgb_c = bar_idx_q;
         PAT_CHECKER: pat_rgb_c = (hc[3] ^ vc[3]) ? 3'b111 : color_bg;
         PAT_FRAME:   pat_rgb_c = frame_cnt_q[7:5];
         default:     pat_rgb_c = color_bg;
      endcase

      beat_d.rgb    = active_c ? pat_rgb_c : 3'b000;
      beat_d.xc     = hc;
      beat_d.yc     = vc;
      beat_d.hs     = in_window(hc, HS_START, HS_END) ? HS_POL : ~HS_POL;
      beat_d.vs     = in_window(vc, VS_START, VS_END) ? VS_POL : ~VS_POL;
      beat_d.active = active_c;
      frame_d       = (hc == '0) && (vc == '0);
   end

   always_ff @(posedge px_clk) begin
      if (reset) begin
         bar_px_q    <= '0;
         bar_idx_q   <= '0;
         frame_cnt_q <= '0;
         pat_q       <= pxs_pattern_e'(pattern);
         beat_q      <= '{rgb: 3'b000, xc: '0, yc: '0, hs: ~HS_POL, vs: ~VS_POL, active: 1'b0};
         frame_q     <= 1'b0;
      end else begin
         bar_px_q    <= bar_px_d;
         bar_idx_q   <= bar_idx_d;
         frame_cnt_q <= frame_cnt_d;
         pat_q       <= pat_d;
         beat_q      <= beat_d;
         frame_q     <= frame_d;
      end
   end

   assign RGBStr_o = beat_q;
   assign frame_o  = frame_q;

endmodule

// File: tb/tb_pxs_vga_source.sv
// Directed bench: a full-size 640x480 instance for line timing and a small
// raster instance so frame-level behaviour fits in a short run.
module tb_pxs_vga_source;

   logic        px_clk  = 1'b0;
   logic        reset   = 1'b1;
   logic [1:0]  pattern = 2'd1;
   logic [25:0] big_s;
   logic        big_f;
   logic [25:0] mini_s;
   logic        mini_f;

   int checks = 0;
   int errors = 0;
   int g      = -1;
   int mini_fr = 0;
   int big_fr  = 0;

   always #5 px_clk = ~px_clk;

   pxs_vga_source u_big (
      .px_clk   (px_clk),
      .reset    (reset),
      .pattern  (pattern),
      .RGBStr_o (big_s),
      .frame_o  (big_f)
   );

   // Small raster: 20 x 12 totals, HS at x 17..18, VS at y 9..10, bars 2 px wide.
   pxs_vga_source #(
      .H_ACTIVE (16), .H_FP (1), .H_SYNC (2), .H_BP (1),
      .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (1),
      .HS_POL   (1'b1), .VS_POL (1'b1), .color_bg (3'b010)
   ) u_mini (
      .px_clk   (px_clk),
      .reset    (reset),
      .pattern  (pattern),
      .RGBStr_o (mini_s),
      .frame_o  (mini_f)
   );

   function automatic logic [25:0] mk(input int rgb, input int xc, input int yc,
                                      input bit hs, input bit vs, input bit act);
      return {3'(rgb), 10'(xc), 10'(yc), hs, vs, act};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge px_clk);
      g++;
      if (mini_f === 1'b1) mini_fr++;
      if (big_f === 1'b1) big_fr++;
   endtask

   task automatic goto(input int t);
      while (g < t) tick();
   endtask

   initial begin
      int hs_cnt   = 0;
      int hs_first = -1;
      int hs_last  = -1;
      int act_cnt  = 0;
      int vs_cnt   = 0;
      int vs_first = -1;

      repeat (5) begin
         @(negedge px_clk);
         chk("rst_big_stream", big_s, 26'h6);
         chk("rst_big_frame", big_f, 0);
         chk("rst_mini_stream", mini_s, 26'h0);
         chk("rst_mini_frame", mini_f, 0);
      end
      reset = 1'b0;

      for (int t = 0; t <= 800; t++) begin
         goto(t);
         if (t < 800) begin
            if (big_s[2] == 1'b0) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = t;
               hs_last = t;
            end
            if (big_s[0]) act_cnt++;
         end
         if (t < 240 && mini_s[1]) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = t;
         end
         case (t)
            0: begin
               chk("first_big_beat", big_s, mk(0, 0, 0, 1, 1, 1));
               chk("first_big_frame", big_f, 1);
               chk("first_mini_beat", mini_s, mk(0, 0, 0, 0, 0, 1));
               chk("first_mini_frame", mini_f, 1);
            end
            1: begin
               chk("big_frame_one_cycle", big_f, 0);
               chk("big_x1", big_s, mk(0, 1, 0, 1, 1, 1));
            end
            2:   chk("mini_bar1_x2", mini_s, mk(1, 2, 0, 0, 0, 1));
            17:  chk("mini_hs_start", mini_s, mk(0, 17, 0, 1, 0, 0));
            19:  chk("mini_hs_end", mini_s, mk(0, 19, 0, 0, 0, 0));
            20:  chk("mini_line1", mini_s, mk(0, 0, 1, 0, 0, 1));
            79:  chk("big_bar0_x79", big_s, mk(0, 79, 0, 1, 1, 1));
            80:  chk("big_bar1_x80", big_s, mk(1, 80, 0, 1, 1, 1));
            155: chk("mini_bar7_last", mini_s, mk(7, 15, 7, 0, 0, 1));
            180: chk("mini_vs_start", mini_s, mk(0, 0, 9, 0, 1, 0));
            219: chk("mini_vs_last", mini_s, mk(0, 19, 10, 0, 1, 0));
            220: chk("mini_vs_end", mini_s, mk(0, 0, 11, 0, 0, 0));
            239: begin
               chk("mini_frame_last", mini_s, mk(0, 19, 11, 0, 0, 0));
               chk("mini_frame_last_f", mini_f, 0);
            end
            240: begin
               chk("mini_frame_wrap", mini_s, mk(0, 0, 0, 0, 0, 1));
               chk("mini_frame_wrap_f", mini_f, 1);
            end
            639: chk("big_bar7_x639", big_s, mk(7, 639, 0, 1, 1, 1));
            640: chk("big_blank_x640", big_s, mk(0, 640, 0, 1, 1, 0));
            655: chk("big_hs_x655", big_s, mk(0, 655, 0, 1, 1, 0));
            656: chk("big_hs_x656", big_s, mk(0, 656, 0, 0, 1, 0));
            751: chk("big_hs_x751", big_s, mk(0, 751, 0, 0, 1, 0));
            752: chk("big_hs_x752", big_s, mk(0, 752, 0, 1, 1, 0));
            799: chk("big_x799", big_s, mk(0, 799, 0, 1, 1, 0));
            800: begin
               chk("big_line1", big_s, mk(0, 0, 1, 1, 1, 1));
               chk("big_line1_frame", big_f, 0);
            end
            default: ;
         endcase
      end
      chk("big_hs_count", hs_cnt, 96);
      chk("big_hs_first", hs_first, 656);
      chk("big_hs_last", hs_last, 751);
      chk("big_active_count", act_cnt, 640);
      chk("mini_vs_count", vs_cnt, 40);
      chk("mini_vs_first", vs_first, 180);

      // Mid-frame switch to checker; bars hold until the frame wrap.
      pattern = 2'd2;
      goto(824);  chk("mini_bars_persist", mini_s, mk(2, 4, 5, 0, 0, 1));
      goto(880);  chk("big_bars_line1", big_s, mk(1, 80, 1, 1, 1, 1));
      goto(959);  chk("mini_pre_wrap", mini_s, mk(0, 19, 11, 0, 0, 0));
      goto(960);  chk("mini_chk_x0", mini_s, mk(2, 0, 0, 0, 0, 1));
      goto(967);  chk("mini_chk_x7", mini_s, mk(2, 7, 0, 0, 0, 1));
      goto(968);  chk("mini_chk_x8", mini_s, mk(7, 8, 0, 0, 0, 1));
      goto(975);  chk("mini_chk_x15", mini_s, mk(7, 15, 0, 0, 0, 1));
      goto(976);  chk("mini_chk_blank", mini_s, mk(0, 16, 0, 0, 0, 0));

      pattern = 2'd0;
      goto(1200); chk("mini_solid_x0", mini_s, mk(2, 0, 0, 0, 0, 1));
      goto(1208); chk("mini_solid_x8", mini_s, mk(2, 8, 0, 0, 0, 1));
      goto(1215); chk("mini_solid_x15", mini_s, mk(2, 15, 0, 0, 0, 1));

      pattern = 2'd3;
      goto(1440);  chk("mini_fc_frame6", mini_s, mk(0, 0, 0, 0, 0, 1));
      goto(7440);  chk("mini_fc_frame31", mini_s, mk(0, 0, 0, 0, 0, 1));
      goto(7455);  chk("mini_fc_f31_x15", mini_s, mk(0, 15, 0, 0, 0, 1));
      goto(7680);  chk("mini_fc_frame32", mini_s, mk(1, 0, 0, 0, 0, 1));
      goto(7835);  chk("mini_fc_f32_last", mini_s, mk(1, 15, 7, 0, 0, 1));
      goto(7836);  chk("mini_fc_f32_blank", mini_s, mk(0, 16, 7, 0, 0, 0));
      goto(61200); chk("mini_fc_frame255", mini_s, mk(7, 0, 0, 0, 0, 1));
      goto(61440);
      chk("mini_fc_wrap256", mini_s, mk(0, 0, 0, 0, 0, 1));
      chk("mini_fc_wrap_f", mini_f, 1);
      chk("mini_frame_pulses", mini_fr, 257);
      chk("big_frame_pulses", big_fr, 1);
      chk("big_at_61440", big_s, mk(0, 640, 76, 1, 1, 0));

      // One-cycle reset in the middle of a line and frame.
      goto(61549);
      chk("mini_pre_reset", mini_s, mk(0, 9, 5, 0, 0, 1));
      chk("big_pre_reset", big_s, mk(0, 749, 76, 0, 1, 0));
      pattern = 2'd1;
      reset   = 1'b1;
      @(negedge px_clk);
      chk("mid_rst_big", big_s, 26'h6);
      chk("mid_rst_big_f", big_f, 0);
      chk("mid_rst_mini", mini_s, 26'h0);
      chk("mid_rst_mini_f", mini_f, 0);
      reset = 1'b0;
      @(negedge px_clk);
      chk("restart_big", big_s, mk(0, 0, 0, 1, 1, 1));
      chk("restart_big_f", big_f, 1);
      chk("restart_mini", mini_s, mk(0, 0, 0, 0, 0, 1));
      chk("restart_mini_f", mini_f, 1);
      @(negedge px_clk);
      chk("restart_big_x1", big_s, mk(0, 1, 0, 1, 1, 1));
      chk("restart_mini_x1", mini_s, mk(0, 1, 0, 0, 0, 1));
      @(negedge px_clk);
      chk("restart_mini_bar1", mini_s, mk(1, 2, 0, 0, 0, 1));
      chk("restart_big_f_low", big_f, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
